// File: rtl/pi_loop_filter_adaptive.sv
// Adaptive-gain PI loop filter: shift-based P/I gains switched between acquire and
// track modes by a lock detector, with a saturating integrator and clamped output.
//
// state    | meaning
// ST_ACQ   | acquiring: wide gains, counting consecutive small-error samples toward lock
// ST_TRACK | locked: narrow gains, counting consecutive large-error samples toward unlock
module pi_loop_filter_adaptive #(
    parameter int ERR_W      = 18,
    parameter int CTRL_W     = 24,
    parameter int KP_ACQ_SH  = 2,
    parameter int KI_ACQ_SH  = 6,
    parameter int KP_TRK_SH  = 4,
    parameter int KI_TRK_SH  = 10,
    parameter int LOCK_THR   = 64,
    parameter int UNLOCK_THR = 256,
    parameter int LOCK_N     = 16,
    parameter int UNLOCK_N   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              phase_valid,
    input  logic [ERR_W-1:0]  phase_err,
    input  logic              hold,
    input  logic              clear_int,
    output logic [CTRL_W-1:0] ctrl,
    output logic              ctrl_valid,
    output logic              locked,
    output logic              int_sat
);

    localparam int XW      = CTRL_W + 2;
    localparam int CNT_MAX = (LOCK_N > UNLOCK_N) ? LOCK_N : UNLOCK_N;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CTRL_W-1:0] MAX_C = {1'b0, {(CTRL_W-1){1'b1}}};
    localparam logic [CTRL_W-1:0] MIN_C = {1'b1, {(CTRL_W-1){1'b0}}};
    localparam logic signed [XW-1:0] MAX_X = XW'($signed(MAX_C));
    localparam logic signed [XW-1:0] MIN_X = XW'($signed(MIN_C));

    localparam logic [ERR_W:0] LOCK_THR_V   = (ERR_W+1)'(LOCK_THR);
    localparam logic [ERR_W:0] UNLOCK_THR_V = (ERR_W+1)'(UNLOCK_THR);
    localparam logic [CNT_W-1:0] LOCK_N_V   = CNT_W'(LOCK_N);
    localparam logic [CNT_W-1:0] UNLOCK_N_V = CNT_W'(UNLOCK_N);

    typedef enum logic {
        ST_ACQ   = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
    logic [CTRL_W-1:0] integ;

    logic                 accept;
    logic signed [XW-1:0] err_x, p, inc;
    logic signed [XW-1:0] p_acq, p_trk, inc_acq, inc_trk;
    logic signed [XW-1:0] i_sum, c_sum;
    logic                 i_hi, i_lo, c_hi, c_lo;
    logic [CTRL_W-1:0]    i_sat_v, i_new, ctrl_new;
    logic                 sat_new;
    logic [ERR_W-1:0]     abs_err;
    logic                 in_lock, out_lock;

    assign accept = ena & phase_valid & ~hold;
    assign locked = (state == ST_TRACK);

    // Gains come from the state before the edge, so a mode switch takes effect next sample.
    assign err_x   = XW'($signed(phase_err));
    assign p_acq   = err_x >>> KP_ACQ_SH;
    assign p_trk   = err_x >>> KP_TRK_SH;
    assign inc_acq = err_x >>> KI_ACQ_SH;
    assign inc_trk = err_x >>> KI_TRK_SH;
    assign p       = (state == ST_TRACK) ? p_trk : p_acq;
    assign inc     = (state == ST_TRACK) ? inc_trk : inc_acq;

    always_comb begin
        i_sum   = XW'($signed(integ)) + inc;
        i_hi    = (i_sum > MAX_X);
        i_lo    = (i_sum < MIN_X);
        i_sat_v = i_hi ? MAX_C : (i_lo ? MIN_C : i_sum[CTRL_W-1:0]);
        i_new   = clear_int ? '0 : i_sat_v;
        sat_new = ~clear_int & (i_hi | i_lo);

        // Output uses the freshly updated integrator, clamped to the same range.
        c_sum    = XW'($signed(i_new)) + p;
        c_hi     = (c_sum > MAX_X);
        c_lo     = (c_sum < MIN_X);
        ctrl_new = c_hi ? MAX_C : (c_lo ? MIN_C : c_sum[CTRL_W-1:0]);
    end

    // Unsigned magnitude: the most negative code maps cleanly to 2^(ERR_W-1).
    assign abs_err  = phase_err[ERR_W-1] ? (~phase_err + ERR_W'(1)) : phase_err;
    assign in_lock  = ({1'b0, abs_err} <= LOCK_THR_V);
    assign out_lock = ({1'b0, abs_err} >  UNLOCK_THR_V);
    assign cnt_inc  = cnt + CNT_W'(1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (accept) begin
            case (state)
                ST_ACQ: begin
                    if (!in_lock) begin
                        cnt_nxt = '0;
                    end else if (cnt_inc == LOCK_N_V) begin
                        state_nxt = ST_TRACK;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                ST_TRACK: begin
                    if (!out_lock) begin
                        cnt_nxt = '0;
                    end else if (cnt_inc == UNLOCK_N_V) begin
                        state_nxt = ST_ACQ;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                default: begin
                    state_nxt = ST_ACQ;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ACQ;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            integ      <= '0;
            ctrl       <= '0;
            ctrl_valid <= 1'b0;
            int_sat    <= 1'b0;
        end else begin
            ctrl_valid <= accept;
            if (accept) begin
                integ   <= i_new;
                ctrl    <= ctrl_new;
                int_sat <= sat_new;
            end else if (clear_int) begin
                integ <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pi_loop_filter_adaptive.sv
// Directed bench for pi_loop_filter_adaptive: hand-computed vectors covering gains,
// saturation, integrator clear, lock/unlock runs, hold/enable gaps and reset.
module tb_pi_loop_filter_adaptive;

    localparam int ERR_W  = 18;
    localparam int CTRL_W = 24;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ena = 1'b0;
    logic              phase_valid = 1'b0;
    logic [ERR_W-1:0]  phase_err = '0;
    logic              hold = 1'b0;
    logic              clear_int = 1'b0;
    logic [CTRL_W-1:0] ctrl;
    logic              ctrl_valid;
    logic              locked;
    logic              int_sat;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pi_loop_filter_adaptive dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .phase_valid(phase_valid),
        .phase_err  (phase_err),
        .hold       (hold),
        .clear_int  (clear_int),
        .ctrl       (ctrl),
        .ctrl_valid (ctrl_valid),
        .locked     (locked),
        .int_sat    (int_sat)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int ctrl_s();
        return int'($signed(ctrl));
    endfunction

    // Drives one cycle of inputs, then samples 1 time unit after the rising edge.
    task automatic cyc(input logic e, input logic pv, input int err,
                       input logic h, input logic c, input logic r);
        ena         = e;
        phase_valid = pv;
        phase_err   = ERR_W'(err);
        hold        = h;
        clear_int   = c;
        rst         = r;
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int err);
        cyc(1'b1, 1'b1, err, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sample_clr(input int err);
        cyc(1'b1, 1'b1, err, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // A valid sample is presented during reset to show reset overrides it.
    task automatic do_reset();
        cyc(1'b1, 1'b1, 1024, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1024, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        do_reset();
        check_val("rst_ctrl", ctrl_s(), 0);
        check_val("rst_valid", int'(ctrl_valid), 0);
        check_val("rst_locked", int'(locked), 0);
        check_val("rst_sat", int'(int_sat), 0);

        // Single acquire sample: p=256, inc=16
        sample(1024);
        check_val("acq_ctrl", ctrl_s(), 272);
        check_val("acq_valid", int'(ctrl_valid), 1);
        check_val("acq_locked", int'(locked), 0);
        idle();
        check_val("acq_valid_pulse", int'(ctrl_valid), 0);
        check_val("acq_ctrl_hold", ctrl_s(), 272);

        // Negative floor rounding and clear without a sample
        do_reset();
        sample(-1);
        check_val("neg_ctrl", ctrl_s(), -2);
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        check_val("clr_only_ctrl", ctrl_s(), -2);
        check_val("clr_only_valid", int'(ctrl_valid), 0);
        sample(0);
        check_val("after_clr_ctrl", ctrl_s(), 0);

        // hold and ena=0 ignore samples
        do_reset();
        cyc(1'b1, 1'b1, 5000, 1'b1, 1'b0, 1'b0);
        check_val("hold_ctrl", ctrl_s(), 0);
        check_val("hold_valid", int'(ctrl_valid), 0);
        cyc(1'b0, 1'b1, 5000, 1'b0, 1'b0, 1'b0);
        check_val("ena0_ctrl", ctrl_s(), 0);
        check_val("ena0_valid", int'(ctrl_valid), 0);

        // Broken lock run, then a full run with hold/ena gaps inside it
        do_reset();
        repeat (15) sample(10);
        check_val("run15_locked", int'(locked), 0);
        sample(100);
        check_val("break_ctrl", ctrl_s(), 26);
        check_val("break_locked", int'(locked), 0);
        repeat (8) sample(10);
        check_val("run8_ctrl", ctrl_s(), 3);
        cyc(1'b1, 1'b1, 5000, 1'b1, 1'b0, 1'b0);
        check_val("gap_hold_ctrl", ctrl_s(), 3);
        check_val("gap_hold_valid", int'(ctrl_valid), 0);
        cyc(1'b0, 1'b1, 5000, 1'b0, 1'b0, 1'b0);
        check_val("gap_ena_ctrl", ctrl_s(), 3);
        check_val("gap_ena_valid", int'(ctrl_valid), 0);
        repeat (7) sample(10);
        check_val("run15b_locked", int'(locked), 0);
        sample(10);
        check_val("run16_locked", int'(locked), 1);

        // Track gains (p = 60>>>4 = 3) with integrator cleared
        sample_clr(60);
        check_val("trk_gain_ctrl", ctrl_s(), 3);
        check_val("trk_gain_locked", int'(locked), 1);
        repeat (3) sample(300);
        check_val("trk_300_ctrl", ctrl_s(), 18);
        check_val("trk_3x_locked", int'(locked), 1);
        sample(0);
        repeat (3) sample(300);
        check_val("trk_3x_again", int'(locked), 1);
        sample(300);
        check_val("unlock_locked", int'(locked), 0);
        check_val("unlock_ctrl", ctrl_s(), 18);
        sample_clr(60);
        check_val("acq_revert_ctrl", ctrl_s(), 15);

        // Integrator saturation and recovery
        do_reset();
        repeat (4200) sample(131071);
        check_val("sat_ctrl", ctrl_s(), 8388607);
        check_val("sat_flag", int'(int_sat), 1);
        check_val("sat_locked", int'(locked), 0);
        sample(-131072);
        check_val("desat_ctrl", ctrl_s(), 8353791);
        check_val("desat_flag", int'(int_sat), 0);

        // Reset mid-saturation and mid-lock-run discards history
        repeat (4200) sample(131071);
        repeat (10) sample(10);
        do_reset();
        check_val("rst2_sat", int'(int_sat), 0);
        check_val("rst2_ctrl", ctrl_s(), 0);
        repeat (15) sample(10);
        check_val("rst2_run15", int'(locked), 0);
        check_val("rst2_run_ctrl", ctrl_s(), 2);
        sample(10);
        check_val("rst2_run16", int'(locked), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
